// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
// Register-file geometry and commit counter width.
package rf_wb_arbiter_pkg;

    localparam int        REG_ADDR_W = 5;
    localparam int        REG_NUM    = 32;
    localparam logic [4:0] REG_ZERO  = 5'd0;
    localparam int        CNT_W      = 16;

endpackage

// File: rtl/rf_wb_arbiter_decoder_5_32.sv
// 5-to-32 one-hot decoder for register-file enables.
// Pure combinational; gating is done by the user.
module decoder_5_32
    import rf_wb_arbiter_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] a,
    output logic [REG_NUM-1:0]    y
);

    // Set exactly the bit selected by the address.
    always_comb begin
        y    = '0;
        y[a] = 1'b1;
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port.
// One-entry output stage; writes to r0 are dropped at accept.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32
)
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         wb_stall,
    output logic [REG_NUM-1:0]           rf_we,
    output logic [REG_ADDR_W-1:0]        rf_waddr,
    output logic [DATA_W-1:0]            rf_wdata,
    output logic [REG_NUM-1:0]           pend_mask,
    output logic [CNT_W-1:0]             commit_cnt
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CW    = PTR_W + 1;

    logic                  out_valid;
    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      gnt_idx;
    logic                  gnt_any;
    logic [CW-1:0]         cand;
    logic                  can_accept;
    logic                  accept;
    logic                  commit;
    logic [REG_ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0]     acc_data;
    logic [REG_NUM-1:0]    dec_y;

    assign can_accept = !out_valid || !wb_stall;
    assign accept     = gnt_any && can_accept;
    assign commit     = out_valid && !wb_stall;
    assign acc_addr   = req_addr[gnt_idx*REG_ADDR_W +: REG_ADDR_W];
    assign acc_data   = req_data[gnt_idx*DATA_W +: DATA_W];

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        gnt_idx = rr_ptr;
        gnt_any = 1'b0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + CW'(k);
            if (cand >= CW'(NUM_REQ))
                cand = cand - CW'(NUM_REQ);
            if (!gnt_any && req_valid[cand[PTR_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[PTR_W-1:0];
            end
        end
    end

    // One-hot ready to the winner, held low during reset.
    always_comb begin
        req_ready = '0;
        if (accept && rst_n)
            req_ready[gnt_idx] = 1'b1;
    end

    // Output stage, pointer and commit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            rr_ptr     <= '0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            commit_cnt <= '0;
        end else begin
            if (commit) begin
                out_valid  <= 1'b0;
                commit_cnt <= commit_cnt + CNT_W'(1);
            end
            if (accept) begin
                rr_ptr <= (gnt_idx == PTR_W'(NUM_REQ - 1))
                        ? '0 : gnt_idx + 1'b1;
                if (acc_addr != REG_ZERO) begin
                    out_valid <= 1'b1;
                    rf_waddr  <= acc_addr;
                    rf_wdata  <= acc_data;
                end
            end
        end
    end

    decoder_5_32 u_dec (
        .a (rf_waddr),
        .y (dec_y)
    );

    assign rf_we     = commit    ? dec_y : '0;
    assign pend_mask = out_valid ? dec_y : '0;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with a commit scoreboard.
// Expected writes are queued at grant and popped at commit.
module tb_rf_wb_arbiter;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        wb_stall;
    logic [31:0] rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pend_mask;
    logic [15:0] commit_cnt;

    logic [2:0]  exp_ready;
    logic [15:0] exp_cnt;
    ent_t        sb[$];
    int          n_checks;
    int          n_err;

    rf_wb_arbiter #(.NUM_REQ(3), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .wb_stall   (wb_stall),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .pend_mask  (pend_mask),
        .commit_cnt (commit_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v,
                           input logic [4:0] a,
                           input logic [31:0] d);
        req_valid[i]       = v;
        req_addr[5*i +: 5] = a;
        req_data[32*i +: 32] = d;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: check commit/hazard outputs, then queue new grants.
    always @(negedge clk) begin
        logic [31:0] m;
        logic        did;
        did = 1'b0;
        if (sb.size() > 0) begin
            m = 32'd1 << sb[0].a;
            check("pend_mask", pend_mask, m);
            if (!wb_stall) begin
                check("rf_we", rf_we, m);
                check("rf_wdata", rf_wdata, sb[0].d);
                void'(sb.pop_front());
                did = 1'b1;
            end else begin
                check("rf_we_stall", rf_we, 32'd0);
            end
        end else begin
            check("rf_we_idle", rf_we, 32'd0);
            check("pend_idle", pend_mask, 32'd0);
        end
        check("commit_cnt", 32'(commit_cnt), 32'(exp_cnt));
        if (did)
            exp_cnt = exp_cnt + 16'd1;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        for (int i = 0; i < 3; i++) begin
            if (req_valid[i] && exp_ready[i] &&
                req_addr[5*i +: 5] != 5'd0)
                sb.push_back('{a: req_addr[5*i +: 5],
                               d: req_data[32*i +: 32]});
        end
    end

    initial begin
        int n;
        n_checks  = 0;
        n_err     = 0;
        exp_cnt   = 16'd0;
        exp_ready = 3'b000;
        rst_n     = 1'b0;
        wb_stall  = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        tick;
        tick;
        check("rst_waddr", 32'(rf_waddr), 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        rst_n = 1'b1;
        tick;

        // Single request to r5.
        set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
        exp_ready = 3'b001;
        tick;
        set_req(0, 1'b0, 5'd0, 32'd0);
        exp_ready = 3'b000;
        tick;
        check("single_cnt", 32'(commit_cnt), 32'd1);

        // Reset while the stage holds a write.
        set_req(2, 1'b1, 5'd4, 32'h44444444);
        exp_ready = 3'b100;
        tick;
        set_req(2, 1'b0, 5'd0, 32'd0);
        exp_ready = 3'b000;
        rst_n     = 1'b0;
        sb.delete();
        exp_cnt   = 16'd0;
        tick;
        check("rst_mid_we", rf_we, 32'd0);
        check("rst_mid_pend", pend_mask, 32'd0);
        check("rst_mid_cnt", 32'(commit_cnt), 32'd0);
        rst_n = 1'b1;
        tick;
        tick;
        check("rst_rel_cnt", 32'(commit_cnt), 32'd0);

        // Round-robin with all three requesters active.
        for (int i = 0; i < 3; i++)
            set_req(i, 1'b1, 5'(i + 1), 32'h1000 + 32'(i));
        for (int k = 0; k < 6; k++) begin
            exp_ready = 3'b001 << (k % 3);
            tick;
            set_req(k % 3, 1'b1, 5'((k % 3) + 1),
                    32'h2000 + 32'(k));
        end
        req_valid = '0;
        exp_ready = 3'b000;
        tick;
        check("rr_cnt", 32'(commit_cnt), 32'd6);

        // Stall with r7 held in the stage.
        set_req(0, 1'b1, 5'd7, 32'h77);
        exp_ready = 3'b001;
        tick;
        set_req(0, 1'b0, 5'd0, 32'd0);
        set_req(1, 1'b1, 5'd8, 32'h88);
        wb_stall  = 1'b1;
        exp_ready = 3'b000;
        for (int k = 0; k < 3; k++) begin
            tick;
            check("stall_addr", 32'(rf_waddr), 32'd7);
            check("stall_data", rf_wdata, 32'h77);
        end
        wb_stall  = 1'b0;
        exp_ready = 3'b010;
        tick;

        // r0 write is granted and dropped.
        set_req(1, 1'b1, 5'd0, 32'hBAD);
        exp_ready = 3'b010;
        tick;
        set_req(1, 1'b1, 5'd10, 32'hA0);
        set_req(2, 1'b1, 5'd11, 32'hB0);
        exp_ready = 3'b100;
        tick;
        set_req(2, 1'b0, 5'd0, 32'd0);
        exp_ready = 3'b010;
        tick;
        set_req(1, 1'b0, 5'd0, 32'd0);
        exp_ready = 3'b000;
        tick;

        // Same address from two requesters.
        set_req(2, 1'b1, 5'd12, 32'hC0);
        exp_ready = 3'b100;
        tick;
        set_req(2, 1'b1, 5'd9, 32'hBBBB0002);
        set_req(0, 1'b1, 5'd9, 32'hAAAA0001);
        exp_ready = 3'b001;
        tick;
        set_req(0, 1'b0, 5'd0, 32'd0);
        exp_ready = 3'b100;
        tick;
        set_req(2, 1'b0, 5'd0, 32'd0);
        exp_ready = 3'b000;
        tick;
        check("same_last", rf_wdata, 32'hBBBB0002);
        tick;

        // Drive the counter to 0xFFFF, then across the wrap.
        n = int'(16'hFFFF - exp_cnt);
        set_req(0, 1'b1, 5'd1, 32'd0);
        exp_ready = 3'b001;
        for (int k = 0; k < n; k++) begin
            set_req(0, 1'b1, 5'd1, 32'(k));
            tick;
        end
        set_req(0, 1'b0, 5'd0, 32'd0);
        exp_ready = 3'b000;
        tick;
        tick;
        check("cnt_max", 32'(commit_cnt), 32'h0000FFFF);
        set_req(0, 1'b1, 5'd2, 32'h5A5A);
        exp_ready = 3'b001;
        tick;
        set_req(0, 1'b0, 5'd0, 32'd0);
        exp_ready = 3'b000;
        tick;
        tick;
        check("cnt_wrap", 32'(commit_cnt), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
